// File: rtl/seq_cell_arc_sequencer.sv
// seq_cell_arc_sequencer: sweeps a set/reset flop through its reset, set, capture-1 and capture-0 arcs, counting output mismatches.
// Define SEQ_ARC_SET_CHECK_EN to include the SET/SET_CHK arc; without it the set arc is skipped and dut_s_o stays low.
module seq_cell_arc_sequencer #(
  parameter int SETTLE = 2,
  parameter int LOOPS = 4
) (
  input  logic       clk_i,
  input  logic       rn_i,
  input  logic       start_i,
  input  logic       dut_q_i,
  output logic       dut_d_o,
  output logic       dut_clk_en_o,
  output logic       dut_r_o,
  output logic       dut_s_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] err_cnt_o
);
  typedef enum logic [3:0] {
    IDLE, RST, RST_CHK,
`ifdef SEQ_ARC_SET_CHECK_EN
    SET, SET_CHK,
`endif
    CAP1, CAP1_CHK, CAP0, CAP0_CHK, DONE
  } state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] loop_q, loop_d, err_q, err_d;
  logic pass_q, pass_d, last, chk, exp_v;
  assign last = cnt_q == 4'(SETTLE - 1);
  always_comb begin
    state_d = state_q;
    loop_d = loop_q;
    pass_d = pass_q;
    chk = 1'b0;
    exp_v = 1'b0;
    cnt_d = (state_q == IDLE || state_q == DONE || last) ? '0 : cnt_q + 4'd1;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RST;
        loop_d = '0;
        pass_d = 1'b0;
      end
      RST: if (last) state_d = RST_CHK;
`ifdef SEQ_ARC_SET_CHECK_EN
      RST_CHK: begin
        chk = last;
        if (last) state_d = SET;
      end
      SET: if (last) state_d = SET_CHK;
      SET_CHK: begin
        chk = last;
        exp_v = 1'b1;
        if (last) state_d = CAP1;
      end
`else
      RST_CHK: begin
        chk = last;
        if (last) state_d = CAP1;
      end
`endif
      CAP1: if (last) state_d = CAP1_CHK;
      CAP1_CHK: begin
        chk = last;
        exp_v = 1'b1;
        if (last) state_d = CAP0;
      end
      CAP0: if (last) state_d = CAP0_CHK;
      CAP0_CHK: begin
        chk = last;
        if (last) begin
          loop_d = loop_q < 8'(LOOPS - 1) ? loop_q + 8'd1 : loop_q;
          state_d = loop_q < 8'(LOOPS - 1) ? RST : DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // X/Z on the cell output must count as a mismatch, hence the case inequality
    err_d = (state_q == IDLE && start_i) ? 8'd0 :
            (chk && (dut_q_i !== exp_v) && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    if (state_d == DONE && state_q != DONE) pass_d = err_d == 8'd0;
  end
  always_ff @(posedge clk_i) begin
    if (!rn_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      loop_q <= '0;
      err_q <= '0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      loop_q <= loop_d;
      err_q <= err_d;
      pass_q <= pass_d;
    end
  end
  assign dut_r_o = state_q == RST || state_q == RST_CHK;
`ifdef SEQ_ARC_SET_CHECK_EN
  assign dut_s_o = state_q == SET || state_q == SET_CHK;
`else
  assign dut_s_o = 1'b0;
`endif
  assign dut_d_o = state_q == CAP1 || state_q == CAP1_CHK;
  assign dut_clk_en_o = last && (state_q == CAP1 || state_q == CAP0);
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign pass_o = pass_q;
  assign err_cnt_o = err_q;
endmodule

// File: tb/tb_seq_cell_arc_sequencer.sv
// tb_seq_cell_arc_sequencer: randomized runs against an arithmetic schedule model of the arc sweep.
module tb_seq_cell_arc_sequencer;
  localparam int SETTLE = 2;
  localparam int LOOPS = 4;
  localparam int SAT_LOOPS = 200;
`ifdef SEQ_ARC_SET_CHECK_EN
  localparam int ARCS = 4;
`else
  localparam int ARCS = 3;
`endif
  localparam int P = 2 * SETTLE;
  localparam int RUN = LOOPS * ARCS * P;
  localparam int SAT_RUN = SAT_LOOPS * ARCS * P;
  logic clk_i = 1'b0;
  logic rn_i = 1'b0;
  logic start_i = 1'b0;
  logic s_start_i = 1'b0;
  logic dut_q_i, dut_d_o, dut_clk_en_o, dut_r_o, dut_s_o, busy_o, done_o, pass_o;
  logic [7:0] err_cnt_o;
  logic s_d, s_en, s_r, s_s, s_busy, s_done, s_pass;
  logic [7:0] s_err;
  logic ff_q = 1'b0;
  logic rnd_q = 1'b0;
  logic beh_q;
  int mode = 0;
  int checks = 0;
  int failures = 0;
  always #5 clk_i = ~clk_i;
  seq_cell_arc_sequencer #(.SETTLE(SETTLE), .LOOPS(LOOPS)) dut (
    .clk_i(clk_i), .rn_i(rn_i), .start_i(start_i), .dut_q_i(dut_q_i),
    .dut_d_o(dut_d_o), .dut_clk_en_o(dut_clk_en_o), .dut_r_o(dut_r_o), .dut_s_o(dut_s_o),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o)
  );
  seq_cell_arc_sequencer #(.SETTLE(SETTLE), .LOOPS(SAT_LOOPS)) dut_sat (
    .clk_i(clk_i), .rn_i(rn_i), .start_i(s_start_i), .dut_q_i(1'b0),
    .dut_d_o(s_d), .dut_clk_en_o(s_en), .dut_r_o(s_r), .dut_s_o(s_s),
    .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass), .err_cnt_o(s_err)
  );
  // behavioural flop: async set/reset, captures D on each enabled cell clock
  always @(posedge clk_i) ff_q <= dut_r_o ? 1'b0 : dut_s_o ? 1'b1 : dut_clk_en_o ? dut_d_o : ff_q;
  assign beh_q = dut_r_o ? 1'b0 : dut_s_o ? 1'b1 : ff_q;
  assign dut_q_i = mode == 0 ? beh_q : mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : rnd_q;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int kind_of(input int a);
    return ARCS == 4 ? a : (a == 0 ? 0 : a + 1);
  endfunction
  function automatic logic exp_bit(input int k);
    int kind;
    kind = kind_of((k / P) % ARCS);
    return kind == 1 || kind == 2;
  endfunction
  function automatic logic [14:0] exp_vec(input int k, input int err);
    int kind, j;
    if (k >= RUN) return {6'b000011, err == 0, 8'(err)};
    kind = kind_of((k / P) % ARCS);
    j = k % P;
    return {kind == 0, kind == 1, kind == 2, kind >= 2 && j == SETTLE - 1, 3'b100, 8'(err)};
  endfunction
  function automatic logic [14:0] outs();
    return {dut_r_o, dut_s_o, dut_d_o, dut_clk_en_o, busy_o, done_o, pass_o, err_cnt_o};
  endfunction
  task automatic run(input int m, input bit stray, input int abort_at);
    int err, en_cnt, dn;
    mode = m;
    err = 0;
    en_cnt = 0;
    dn = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int k = 0; k <= RUN; k++) begin
      start_i = stray && (k == 9 || k == RUN - 1);
      rnd_q = 1'($urandom);
      #1;
      check("cycle", 32'(outs()), 32'(exp_vec(k, err)));
      en_cnt += int'(dut_clk_en_o);
      dn += int'(done_o);
      if (k < RUN && k % P == P - 1 && dut_q_i !== exp_bit(k)) err = err == 255 ? 255 : err + 1;
      if (k == abort_at) begin
        rn_i = 1'b0;
        @(negedge clk_i);
        rn_i = 1'b1;
        check("abort_outs", 32'(outs()), 0);
        dn = 0;
        for (int i = 0; i < RUN + 4; i++) begin
          @(negedge clk_i);
          dn += int'(done_o);
        end
        check("abort_no_done", dn, 0);
        check("abort_idle", 32'(busy_o), 0);
        return;
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    check("clk_en_pulses", en_cnt, 2 * LOOPS);
    check("done_pulses", dn, 1);
    check("idle_hold", {busy_o, done_o, pass_o, err_cnt_o}, {2'b00, err == 0, 8'(err)});
  endtask
  initial begin
    int t;
    repeat (3) @(negedge clk_i);
    check("reset_outs", 32'(outs()), 0);
    check("reset_sat_outs", {s_d, s_en, s_r, s_s, s_busy, s_done, s_pass, s_err}, 0);
    rn_i = 1'b1;
    @(negedge clk_i);
    run(0, 1'b0, -1);
    run(1, 1'b0, -1);
    run(2, 1'b0, -1);
    run(0, 1'b1, -1);
    run(0, 1'b0, 19);
    run(0, 1'b0, -1);
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
      run(int'($urandom_range(0, 3)), 1'($urandom), -1);
    end
    mode = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while (!done_o && t < 2 * RUN);
    check("hold_first_len", t, RUN + 1);
    @(negedge clk_i);
    check("hold_idle_gap", 32'(busy_o), 0);
    @(negedge clk_i);
    check("hold_restart", {busy_o, dut_r_o}, 2'b11);
    start_i = 1'b0;
    t = 0;
    while (!done_o && t < 2 * RUN) begin
      @(negedge clk_i);
      t++;
    end
    check("hold_second_len", t, RUN);
    check("hold_second_pass", {pass_o, err_cnt_o}, {1'b1, 8'd0});
    @(negedge clk_i);
    s_start_i = 1'b1;
    @(negedge clk_i);
    s_start_i = 1'b0;
    t = 0;
    while (!s_done && t < SAT_RUN + 10) begin
      @(negedge clk_i);
      t++;
    end
    check("sat_len", t, SAT_RUN);
    check("sat_err", 32'(s_err), (SAT_LOOPS * (ARCS - 2) > 255) ? 255 : SAT_LOOPS * (ARCS - 2));
    check("sat_pass", 32'(s_pass), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
